// File: rtl/serial_word_rx_pkg.sv
// Shared definitions for the serial word link: FSM state encodings and default frame width.
// The transmitter imports the same package so both ends agree on the encoding.
package serial_word_rx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

endpackage

// File: rtl/serial_word_rx_bit_counter.sv
// bit_counter: received-bit counter with sync clear and enable. Clear and enable
// together load 1, so a start bit can restart the count in one edge.
module bit_counter #(
  parameter int MAXV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(MAXV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (clr_i ? '0 : cnt_q) + CW'(en_i);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // High while the next captured bit is the last data bit of the frame.
  assign tc_o = (cnt_q == CW'(MAXV - 1));

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with a valid/ready output register.
// Optional even parity bit per frame when SERIAL_WORD_RX_PARITY_EN is defined.
module serial_word_rx
  import serial_word_rx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_start,
  input  logic             s_in,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             p_err,
  output logic             overrun,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] shifted, first_bits, word_c;
  logic             cnt_clr, cnt_en, tc, done;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             p_valid_q, p_valid_d;
  logic             overrun_q, overrun_d;
`ifdef SERIAL_WORD_RX_PARITY_EN
  logic             err_c, p_err_q, p_err_d;
`endif

  bit_counter #(.MAXV(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted    = {sr_q[WIDTH-2:0], s_in};
      first_bits = {{(WIDTH-1){1'b0}}, s_in};
    end else begin
      shifted    = {s_in, sr_q[WIDTH-1:1]};
      first_bits = {s_in, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    done    = 1'b0;
    word_c  = shifted;
`ifdef SERIAL_WORD_RX_PARITY_EN
    err_c   = 1'b0;
`endif
    // A start bit always begins a new frame, silently dropping any partial one.
    if (s_valid && s_start) begin
      state_d = ST_SHIFT;
      sr_d    = first_bits;
      cnt_clr = 1'b1;
      cnt_en  = 1'b1;
    end else if (s_valid) begin
      case (state_q)
        ST_SHIFT: begin
          sr_d   = shifted;
          cnt_en = 1'b1;
          if (tc) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_IDLE;
            done    = 1'b1;
            sr_d    = '0;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
`endif
          end
        end
`ifdef SERIAL_WORD_RX_PARITY_EN
        ST_PAR: begin
          state_d = ST_IDLE;
          done    = 1'b1;
          word_c  = sr_q;
          err_c   = ^{sr_q, s_in};
          sr_d    = '0;
          cnt_clr = 1'b1;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    p_data_d  = p_data_q;
    p_valid_d = p_valid_q;
    overrun_d = overrun_q;
`ifdef SERIAL_WORD_RX_PARITY_EN
    p_err_d   = p_err_q;
`endif
    if (done) begin
      if (!p_valid_q || p_ready) begin
        p_data_d  = word_c;
        p_valid_d = 1'b1;
`ifdef SERIAL_WORD_RX_PARITY_EN
        p_err_d   = err_c;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (p_valid_q && p_ready) begin
      p_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SERIAL_WORD_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) p_err_q <= 1'b0;
    else     p_err_q <= p_err_d;
  end
  assign p_err = p_err_q;
`else
  assign p_err = 1'b0;
`endif

  assign p_data  = p_data_q;
  assign p_valid = p_valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: queue-based frame model compared every cycle, plus
// directed literal checks and randomized frames/back-pressure.
module tb_serial_word_rx;

  localparam int W = 8;
`ifdef SERIAL_WORD_RX_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0, s_start = 1'b0, s_in = 1'b0;
  logic         p_ready = 1'b0;
  logic [W-1:0] p_data;
  logic         p_valid, p_err, overrun, busy;

  int  errors = 0;
  int  checks = 0;
  bit  rand_rdy = 1'b0;

  serial_word_rx #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_start(s_start), .s_in(s_in),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready), .p_err(p_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: the frame is just the list of bits received since the last start.
  bit           frame[$];
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0, m_err = 1'b0, m_ovr = 1'b0;

  always @(posedge clk) begin
    bit           fin;
    logic [W-1:0] w;
    logic         e;
    fin = 1'b0; w = '0; e = 1'b0;
    if (rst) begin
      frame.delete();
      m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    end else begin
      if (s_valid) begin
        if (s_start) begin
          frame.delete();
          frame.push_back(s_in);
        end else if (frame.size() > 0) begin
          frame.push_back(s_in);
        end
        if (frame.size() == FLEN) begin
          fin = 1'b1;
          for (int i = 0; i < W; i++) w[W-1-i] = frame[i];
`ifdef SERIAL_WORD_RX_PARITY_EN
          e = (^w) ^ frame[W];
`endif
          frame.delete();
        end
      end
      if (fin) begin
        if (!m_valid || p_ready) begin
          m_data = w; m_err = e; m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && p_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_p_valid", 32'(p_valid), 32'(m_valid));
    chk("cyc_p_data",  32'(p_data),  32'(m_data));
    chk("cyc_p_err",   32'(p_err),   32'(m_err));
    chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
    chk("cyc_busy",    32'(busy),    32'(frame.size() > 0));
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) p_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic b, input logic st);
    s_valid = 1'b1; s_start = st; s_in = b;
    tick();
    s_valid = 1'b0; s_start = 1'b0; s_in = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Parity bit sent is even parity, flipped when bad_par is set; no gap after the last bit.
  task automatic send_word(input logic [W-1:0] w, input int gapmax, input bit bad_par);
    for (int i = 0; i < W; i++) begin
      send_bit(w[W-1-i], i == 0);
`ifdef SERIAL_WORD_RX_PARITY_EN
      if (gapmax > 0) idle($urandom_range(0, gapmax));
`else
      if (gapmax > 0 && i < W-1) idle($urandom_range(0, gapmax));
`endif
    end
`ifdef SERIAL_WORD_RX_PARITY_EN
    send_bit((^w) ^ bad_par, 1'b0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    do_reset();

    // Reset in the middle of a frame drops it; a following non-start bit is ignored.
    send_bit(1, 1); send_bit(1, 0); send_bit(0, 0);
    rst = 1'b1; tick(); tick();
    chk("rst_p_valid", 32'(p_valid), 0);
    chk("rst_p_data",  32'(p_data),  0);
    chk("rst_busy",    32'(busy),    0);
    rst = 1'b0;
    send_bit(1, 0);
    chk("rst_stray_busy", 32'(busy), 0);

    // Alternating bits, MSB first.
    p_ready = 1'b1;
    send_word(8'h55, 0, 0);
    chk("alt_p_data",  32'(p_data),  32'h55);
    chk("alt_p_valid", 32'(p_valid), 1);
    chk("alt_p_err",   32'(p_err),   0);
    tick();
    chk("alt_one_cycle", 32'(p_valid), 0);

    // Back-pressure: second word dropped, overrun latched.
    p_ready = 1'b0;
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 0, 0);
    chk("bp_p_data",  32'(p_data),  32'hA5);
    chk("bp_overrun", 32'(overrun), 1);
    p_ready = 1'b1;
    tick();
    chk("bp_drop", 32'(p_valid), 0);

    // Accept and completion on the same edge.
    do_reset();
    p_ready = 1'b0;
    send_word(8'h5A, 0, 0);
    w = 8'hC3;
`ifdef SERIAL_WORD_RX_PARITY_EN
    for (int i = 0; i < W; i++) send_bit(w[W-1-i], i == 0);
    p_ready = 1'b1;
    send_bit(^w, 1'b0);
`else
    for (int i = 0; i < W-1; i++) send_bit(w[W-1-i], i == 0);
    p_ready = 1'b1;
    send_bit(w[0], 1'b0);
`endif
    chk("sim_p_data",  32'(p_data),  32'hC3);
    chk("sim_p_valid", 32'(p_valid), 1);
    chk("sim_overrun", 32'(overrun), 0);
    tick();

    // Abort after 4 bits, restart with a new start bit.
    send_bit(1, 1); send_bit(1, 0); send_bit(1, 0); send_bit(1, 0);
    chk("abort_none", 32'(p_valid), 0);
    send_word(8'hF0, 0, 0);
    chk("abort_p_data", 32'(p_data), 32'hF0);

    // Gaps between bits; parity good then bad.
    tick();
    send_word(8'h07, 3, 0);
    chk("gap_p_data", 32'(p_data), 32'h07);
    chk("gap_p_err",  32'(p_err),  0);
    tick();
`ifdef SERIAL_WORD_RX_PARITY_EN
    send_word(8'h07, 3, 1);
    chk("par_bad_p_data", 32'(p_data), 32'h07);
    chk("par_bad_p_err",  32'(p_err),  1);
    tick();
`endif

    // Random traffic against the model.
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 70) begin
        send_word(W'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      end else if (sel < 82) begin
        int k;
        k = $urandom_range(1, FLEN - 1);
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), i == 0);
      end else if (sel < 95) begin
        send_bit(1'($urandom_range(0, 1)), 1'b0);
      end else if (sel < 98) begin
        idle($urandom_range(1, 4));
      end else begin
        do_reset();
      end
    end
    rand_rdy = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
